// File: rtl/pixel_array_ss_adc_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_array_ss_adc_if
// Purpose  : Valid/ready readout bus carrying pixel codes and pixel indices
//            out of the single-slope ADC pixel array.
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_array_ss_adc_if #(
   parameter int ADC_BITS = 8,
   parameter int IDX_W    = 2
);
   logic [ADC_BITS-1:0] dout;
   logic [IDX_W-1:0]    dout_idx;
   logic                dout_valid;
   logic                dout_ready;

   // Source side (the pixel array)
   modport master (
      output dout,
      output dout_idx,
      output dout_valid,
      input  dout_ready
   );

   // Sink side (readout / ISP front-end)
   modport slave (
      input  dout,
      input  dout_idx,
      input  dout_valid,
      output dout_ready
   );
endinterface
`default_nettype wire

// File: rtl/pixel_array_ss_adc.sv
`default_nettype none
// ============================================================================
// Module   : pixel_array_ss_adc
// Purpose  : NUM_PIX column-parallel pixels sharing one single-slope ADC ramp.
//            A frame FSM runs erase, exposure, conversion and a valid/ready
//            serial readout of the per-pixel codes.
// Options  : PIXEL_CDS_EN - correlated double sampling (adds pix_offset_i and
//            a reset-level conversion between erase and exposure).
// Revision : 1.0 - initial release
// ============================================================================
module pixel_array_ss_adc #(
   parameter int ADC_BITS = 8,
   parameter int NUM_PIX  = 4,
   parameter int PHOTO_W  = 4,
   parameter int EXP_W    = 16
) (
   input  wire logic                        clk_i,
   input  wire logic                        rst_n_i,
   input  wire logic                        start_i,
   input  wire logic                        abort_i,
   input  wire logic [EXP_W-1:0]            expose_cycles_i,
   input  wire logic [NUM_PIX*PHOTO_W-1:0]  photo_i,
`ifdef PIXEL_CDS_EN
   input  wire logic [NUM_PIX*ADC_BITS-1:0] pix_offset_i,
`endif
   output logic                             busy_o,
   output logic                             frame_done_o,
   pixel_array_ss_adc_if.master             rd_if
);

   localparam int                IDX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
   localparam int                SUB_W = (ADC_BITS > PHOTO_W) ? ADC_BITS : PHOTO_W;
   localparam logic [ADC_BITS-1:0] FULL     = {ADC_BITS{1'b1}};
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_PIX - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ERASE    = 3'd1,
      S_EXPOSE   = 3'd2,
      S_CONVERT  = 3'd3,
      S_READOUT  = 3'd4,
      S_DONE     = 3'd5
`ifdef PIXEL_CDS_EN
      ,
      S_RST_CONV = 3'd6
`endif
   } state_e;

   state_e                state_q,   state_d;
   logic [EXP_W-1:0]      exp_cnt_q, exp_cnt_d;
   logic [ADC_BITS-1:0]   ramp_q,    ramp_d;
   logic [ADC_BITS-1:0]   lvl_q      [NUM_PIX];
   logic [ADC_BITS-1:0]   lvl_d      [NUM_PIX];
   logic [ADC_BITS-1:0]   code_q     [NUM_PIX];
   logic [ADC_BITS-1:0]   code_d     [NUM_PIX];
   logic [NUM_PIX-1:0]    tripped_q, tripped_d;
   logic [IDX_W-1:0]      idx_q,     idx_d;
   logic                  valid_q,   valid_d;
`ifdef PIXEL_CDS_EN
   logic [ADC_BITS-1:0]   rst_code_q [NUM_PIX];
   logic [ADC_BITS-1:0]   rst_code_d [NUM_PIX];
`endif

   // Photo discharge clamps at an empty well instead of wrapping round.
   function automatic logic [ADC_BITS-1:0] sat_sub(input logic [ADC_BITS-1:0] a,
                                                   input logic [PHOTO_W-1:0]  b);
      logic [SUB_W-1:0] a_ext;
      logic [SUB_W-1:0] b_ext;
      a_ext = SUB_W'(a);
      b_ext = SUB_W'(b);
      return (b_ext >= a_ext) ? '0 : ADC_BITS'(a_ext - b_ext);
   endfunction

   // Frame sequencing plus the shared-ramp pixel datapath (next-state logic).
   always_comb begin
      state_d   = state_q;
      exp_cnt_d = exp_cnt_q;
      ramp_d    = ramp_q;
      lvl_d     = lvl_q;
      code_d    = code_q;
      tripped_d = tripped_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
`ifdef PIXEL_CDS_EN
      rst_code_d = rst_code_q;
`endif

      if (abort_i) begin
         // Abort wins over everything; codes stay as they are.
         state_d = S_IDLE;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  exp_cnt_d = expose_cycles_i;
                  state_d   = S_ERASE;
               end
            end

            S_ERASE: begin
               for (int i = 0; i < NUM_PIX; i++) begin
`ifdef PIXEL_CDS_EN
                  lvl_d[i] = FULL - pix_offset_i[i*ADC_BITS +: ADC_BITS];
`else
                  lvl_d[i] = FULL;
`endif
               end
               tripped_d = '0;
               ramp_d    = '0;
`ifdef PIXEL_CDS_EN
               state_d   = S_RST_CONV;
`else
               state_d   = (exp_cnt_q == '0) ? S_CONVERT : S_EXPOSE;
`endif
            end

`ifdef PIXEL_CDS_EN
            S_RST_CONV: begin
               for (int i = 0; i < NUM_PIX; i++) begin
                  if (!tripped_q[i] && (ramp_q >= lvl_q[i])) begin
                     rst_code_d[i] = ramp_q;
                     tripped_d[i]  = 1'b1;
                  end
               end
               if (ramp_q == FULL) begin
                  // Re-arm the comparators and the ramp for the signal pass.
                  tripped_d = '0;
                  ramp_d    = '0;
                  state_d   = (exp_cnt_q == '0) ? S_CONVERT : S_EXPOSE;
               end else begin
                  ramp_d = ramp_q + 1'b1;
               end
            end
`endif

            S_EXPOSE: begin
               for (int i = 0; i < NUM_PIX; i++) begin
                  lvl_d[i] = sat_sub(lvl_q[i], photo_i[i*PHOTO_W +: PHOTO_W]);
               end
               exp_cnt_d = exp_cnt_q - 1'b1;
               if (exp_cnt_q <= EXP_W'(1)) begin
                  state_d = S_CONVERT;
               end
            end

            S_CONVERT: begin
               for (int i = 0; i < NUM_PIX; i++) begin
                  if (!tripped_q[i] && (ramp_q >= lvl_q[i])) begin
                     code_d[i]    = ramp_q;
                     tripped_d[i] = 1'b1;
                  end
               end
               if (ramp_q == FULL) begin
                  state_d = S_READOUT;
                  valid_d = 1'b1;
                  idx_d   = '0;
               end else begin
                  ramp_d = ramp_q + 1'b1;
               end
            end

            S_READOUT: begin
               if (valid_q && rd_if.dout_ready) begin
                  if (idx_q == LAST_IDX) begin
                     valid_d = 1'b0;
                     state_d = S_DONE;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end

            S_DONE: begin
               state_d = S_IDLE;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous return to the erased state.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         exp_cnt_q <= '0;
         ramp_q    <= '0;
         tripped_q <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         for (int i = 0; i < NUM_PIX; i++) begin
            lvl_q[i]  <= FULL;
            code_q[i] <= '0;
`ifdef PIXEL_CDS_EN
            rst_code_q[i] <= '0;
`endif
         end
      end else begin
         state_q   <= state_d;
         exp_cnt_q <= exp_cnt_d;
         ramp_q    <= ramp_d;
         tripped_q <= tripped_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         lvl_q     <= lvl_d;
         code_q    <= code_d;
`ifdef PIXEL_CDS_EN
         rst_code_q <= rst_code_d;
`endif
      end
   end

   // Readout data is a mux of registered codes, forced to zero between beats.
   always_comb begin
      rd_if.dout       = '0;
      rd_if.dout_idx   = '0;
      rd_if.dout_valid = valid_q;
      if (valid_q) begin
         rd_if.dout_idx = idx_q;
`ifdef PIXEL_CDS_EN
         // Reset-level minus signal-level cancels the per-pixel offset.
         rd_if.dout = FULL - (rst_code_q[idx_q] - code_q[idx_q]);
`else
         rd_if.dout = code_q[idx_q];
`endif
      end
   end

   assign busy_o       = (state_q != S_IDLE);
   assign frame_done_o = (state_q == S_DONE);

endmodule
`default_nettype wire
